requant_pipeline: RTL and testbench
===================================

// Module: requant_pipeline
// PURPOSE
//  Multi-lane, fully pipelined int32->intN requantizer (TFLite MultiplyByQuantizedMultiplier + offset + clamp).
//  Successor to the one-shot SRDHM/RDBPOT FSMs: one vector of LANES accumulators per cycle.
//  Per-lane multiplier/shift, valid/ready flow control. Sits behind the TPU C buffer inside Cfu.
// PARAMETERS
//  LANES     4  number of parallel int32 lanes
//  OUT_BITS  8  signed output width per lane (2..32)
// PORTS
//  clk            in   1              clock; all logic on posedge
//  reset          in   1              synchronous, active-high
//  cfg_we         in   1              write per-lane config for lane cfg_lane
//  cfg_lane       in   $clog2(LANES)  lane index
//  cfg_mult       in   32             Q31 multiplier (signed)
//  cfg_shift      in   6              signed shift: >0 left, <0 right; valid range -31..+31
//  cfg_glb_we     in   1              write global config
//  cfg_out_off    in   32             signed output offset
//  cfg_act_min    in   32             signed clamp low
//  cfg_act_max    in   32             signed clamp high
//  in_valid       in   1              input vector valid
//  in_ready       out  1              input accepted when in_valid && in_ready
//  in_data        in   LANES*32       lane i = bits [32*i+31 : 32*i], signed
//  out_valid      out  1              output vector valid
//  out_ready      in   1              consumer ready
//  out_data       out  LANES*OUT_BITS lane i = bits [OUT_BITS*i +: OUT_BITS], signed
//  busy           out  1              any stage holds valid data
// BEHAVIOUR
//  Reset: all stage valids 0; out_valid=0; out_data=0; busy=0; in_ready=1.
//   Config: mult=0x40000000, shift=0, out_off=0, act_min=-2^(OUT_BITS-1), act_max=2^(OUT_BITS-1)-1.
//  Reset mid-operation: in-flight data is discarded; no output is emitted.
//  Pipeline: 5 stages, global stall. adv = ~out_valid | out_ready; in_ready = adv.
//   All stage registers load only when adv=1.
//   Latency: exactly 5 cycles, accept to out_valid, when unstalled. Throughput: 1 vector/cycle.
//   Bubbles propagate and are not compressed.
//  Config capture: lane mult/shift and global config are sampled with the data at accept.
//   cfg_we in the same cycle as an accept uses the OLD value; the new value applies from the next cycle.
//  S1: ls = max(shift,0), rs = max(-shift,0).
//   a = x << ls, wrapping 32-bit (no saturation).
//  S2: p = signed a * signed mult, full 64-bit.
//  S3 (SRDHM): nudge = p<0 ? 1-2^30 : 2^30; h = trunc_toward_zero((p+nudge)/2^31), 32-bit.
//   If a==mult==0x80000000, h = 0x7FFFFFFF.
//  S4 (RDBPOT): mask = (1<<rs)-1; rem = h & mask; thr = (mask>>1) + h[31].
//   r = (h >>> rs) + (rem > thr ? 1 : 0). rs=0 gives r=h.
//  S5: v = r + out_off, 32-bit wrap.
//   c = min(max(v, act_min), act_max); act_min>act_max gives act_max.
//   out lane = c[OUT_BITS-1:0].
//  Hold rule: out_data/out_valid stay stable while out_valid && ~out_ready.
//  Simultaneous cfg_we and cfg_glb_we are both performed.
//  Out-of-range cfg_lane is ignored.
//  busy = OR of S1..S5 valids.
// STRUCTURE
//  Package requant_pkg: INT32_MIN, NUDGE_POS=64'h40000000, NUDGE_NEG=64'hFFFFFFFFC0000001, STAGES=5.
//  Sub-module requant_lane: one lane's S1..S5 datapath, enabled by adv; instantiated LANES times.
//  Top module holds the config regs, valid chain, handshake and busy.
// TESTING
//  1 basic: x=100, mult=0x40000000, shift=0 -> 50 on lane, exactly 5 cycles after accept.
//  2 neg rounding: x=-3, mult=0x40000000, shift=-1 -> h=-1, r=-1, out 8'hFF.
//  3 overflow+clamp: x=mult=0x80000000, shift=0 -> h=0x7FFFFFFF, out 127 (OUT_BITS=8).
//  4 left shift+offset: x=3, mult=0x40000000, shift=+2, out_off=10 -> 16.
//   Other lanes carry distinct configs; check no cross-lane mixing.
//  5 backpressure: stream 8 vectors, out_ready=0 for 3 cycles mid-stream.
//   Require in_ready=0 while stalled, out_data stable, all 8 delivered once, in order.
//  6 reset mid-op: 3 vectors in flight, reset 1 cycle.
//   Next cycle: out_valid=0, busy=0, config at defaults; nothing emitted afterwards.
//   Plus: cfg_we on the accept cycle -> that vector uses the old multiplier.

Source files
------------

// File: rtl/requant_pkg.sv
// Shared constants and types for the multi-lane int32 -> intN requantizer.
package requant_pkg;

    localparam logic [31:0] INT32_MIN = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [63:0] NUDGE_POS = 64'h0000_0000_4000_0000;
    localparam logic [63:0] NUDGE_NEG = 64'hFFFF_FFFF_C000_0001;
    localparam logic [31:0] MULT_DEF  = 32'h4000_0000;
    localparam int unsigned STAGES    = 5;

    typedef struct packed {
        logic [31:0] out_off;
        logic [31:0] act_min;
        logic [31:0] act_max;
    } glb_cfg_t;

endpackage

// File: rtl/requant_lane.sv
// One lane of the requantizer: shift, Q31 multiply, SRDHM, RDBPOT, offset and clamp.
module requant_lane
    import requant_pkg::*;
#(
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                adv,
    input  logic [31:0]         x,
    input  logic [31:0]         mult,
    input  logic [5:0]          shift,
    input  glb_cfg_t            glb,
    output logic [OUT_BITS-1:0] q
);

    logic [4:0]          ls;
    logic [5:0]          rs;
    logic [31:0]         a1_q, m1_q;
    logic [5:0]          rs1_q, rs2_q, rs3_q;
    logic [63:0]         p2_d, p2_q;
    logic                ovf2_q;
    logic [63:0]         sum3, adj3;
    logic [31:0]         h3_d, h3_q;
    logic [31:0]         mask4, rem4, thr4, r4_d, r4_q;
    logic signed [31:0]  v5, c5;
    logic [OUT_BITS-1:0] q_q;

    always_comb begin
        ls = '0;
        rs = '0;
        if (shift[5]) rs = 6'(-shift);
        else          ls = shift[4:0];
    end

    always_comb begin
        p2_d = $signed({{32{a1_q[31]}}, a1_q}) * $signed({{32{m1_q[31]}}, m1_q});
    end

    // Bias negative sums by 2^31-1 so the arithmetic shift truncates toward zero.
    always_comb begin
        sum3 = p2_q + (p2_q[63] ? NUDGE_NEG : NUDGE_POS);
        adj3 = sum3 + (sum3[63] ? 64'h0000_0000_7FFF_FFFF : 64'h0);
        h3_d = ovf2_q ? INT32_MAX : 32'($signed(adj3) >>> 31);
    end

    always_comb begin
        mask4 = (32'h1 << rs3_q) - 32'h1;
        rem4  = h3_q & mask4;
        thr4  = (mask4 >> 1) + {31'b0, h3_q[31]};
        r4_d  = 32'($signed(h3_q) >>> rs3_q) + {31'b0, rem4 > thr4};
    end

    // Clamp low first, then high, so an inverted range resolves to act_max.
    always_comb begin
        v5 = $signed(r4_q + glb.out_off);
        c5 = v5;
        if (c5 < $signed(glb.act_min)) c5 = $signed(glb.act_min);
        if (c5 > $signed(glb.act_max)) c5 = $signed(glb.act_max);
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            a1_q   <= x << ls;
            m1_q   <= mult;
            rs1_q  <= rs;
            p2_q   <= p2_d;
            ovf2_q <= (a1_q == INT32_MIN) && (m1_q == INT32_MIN);
            rs2_q  <= rs1_q;
            h3_q   <= h3_d;
            rs3_q  <= rs2_q;
            r4_q   <= r4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    q_q <= '0;
        else if (adv) q_q <= OUT_BITS'(c5);
    end

    assign q = q_q;

endmodule

// File: rtl/requant_pipeline.sv
// Multi-lane 5-stage requantizer with per-lane mult/shift, global offset/clamp and valid/ready.
module requant_pipeline
    import requant_pkg::*;
#(
    parameter int unsigned LANES    = 4,
    parameter int unsigned OUT_BITS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cfg_we,
    input  logic [$clog2(LANES)-1:0]  cfg_lane,
    input  logic [31:0]               cfg_mult,
    input  logic [5:0]                cfg_shift,
    input  logic                      cfg_glb_we,
    input  logic [31:0]               cfg_out_off,
    input  logic [31:0]               cfg_act_min,
    input  logic [31:0]               cfg_act_max,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*32-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_BITS-1:0] out_data,
    output logic                      busy
);

    localparam int unsigned LW          = $clog2(LANES);
    localparam logic [31:0] ACT_MAX_DEF = 32'((64'd1 << (OUT_BITS - 1)) - 64'd1);
    localparam logic [31:0] ACT_MIN_DEF = ~ACT_MAX_DEF;

    logic [31:0]       mult_q  [LANES];
    logic [5:0]        shift_q [LANES];
    glb_cfg_t          glb_q;
    glb_cfg_t          glb_pipe_q [STAGES-1];
    logic [STAGES-1:0] valid_q;
    logic              adv;

    assign adv       = ~valid_q[STAGES-1] | out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[STAGES-1];
    assign busy      = |valid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                mult_q[i]  <= MULT_DEF;
                shift_q[i] <= '0;
            end
            glb_q <= '{out_off: 32'h0, act_min: ACT_MIN_DEF, act_max: ACT_MAX_DEF};
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (cfg_we && cfg_lane == LW'(i)) begin
                    mult_q[i]  <= cfg_mult;
                    shift_q[i] <= cfg_shift;
                end
            end
            if (cfg_glb_we) begin
                glb_q <= '{out_off: cfg_out_off, act_min: cfg_act_min, act_max: cfg_act_max};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)    valid_q <= '0;
        else if (adv) valid_q <= {valid_q[STAGES-2:0], in_valid};
    end

    // Global config travels with the data so it is applied at S5 as sampled at accept.
    always_ff @(posedge clk) begin
        if (adv) begin
            glb_pipe_q[0] <= glb_q;
            for (int i = 1; i < STAGES - 1; i++) glb_pipe_q[i] <= glb_pipe_q[i-1];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        requant_lane #(
            .OUT_BITS(OUT_BITS)
        ) u_lane (
            .clk  (clk),
            .reset(reset),
            .adv  (adv),
            .x    (in_data[32*g +: 32]),
            .mult (mult_q[g]),
            .shift(shift_q[g]),
            .glb  (glb_pipe_q[STAGES-2]),
            .q    (out_data[OUT_BITS*g +: OUT_BITS])
        );
    end

endmodule

// File: tb/tb_requant_pipeline.sv
// Directed self-checking bench for requant_pipeline (LANES=4, OUT_BITS=8).
module tb_requant_pipeline;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg_we;
    logic [1:0]   cfg_lane;
    logic [31:0]  cfg_mult;
    logic [5:0]   cfg_shift;
    logic         cfg_glb_we;
    logic [31:0]  cfg_out_off, cfg_act_min, cfg_act_max;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready;
    logic [31:0]  out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    requant_pipeline #(
        .LANES   (4),
        .OUT_BITS(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_lane   (cfg_lane),
        .cfg_mult   (cfg_mult),
        .cfg_shift  (cfg_shift),
        .cfg_glb_we (cfg_glb_we),
        .cfg_out_off(cfg_out_off),
        .cfg_act_min(cfg_act_min),
        .cfg_act_max(cfg_act_max),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lane_cfg(input logic [1:0] lane, input logic [31:0] mult,
                            input logic [5:0] shift);
        cfg_we = 1'b1; cfg_lane = lane; cfg_mult = mult; cfg_shift = shift;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic glb_cfg(input logic [31:0] off, input logic [31:0] lo, input logic [31:0] hi);
        cfg_glb_we = 1'b1; cfg_out_off = off; cfg_act_min = lo; cfg_act_max = hi;
        step();
        cfg_glb_we = 1'b0;
    endtask

    // Send one vector, wait for it, check latency and data.
    task automatic run_vec(input string tag, input logic [127:0] d, input logic [31:0] exp);
        int lat;
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd5);
        check({tag, "_data"}, out_data, exp);
        step();
    endtask

    function automatic logic [127:0] bp_vec(input int k);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = 32'(20 * k + 2 * i);
        return v;
    endfunction

    function automatic logic [31:0] bp_exp(input int k);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'(10 * k + i);
        return r;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int sent, recv, cnt;
        logic acc, stalled_prev;
        logic [31:0] held;

        reset = 1'b1; cfg_we = 1'b0; cfg_lane = '0; cfg_mult = '0; cfg_shift = '0;
        cfg_glb_we = 1'b0; cfg_out_off = '0; cfg_act_min = '0; cfg_act_max = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", out_data, 32'd0);
        reset = 1'b0;
        step();

        // Defaults: x/2 rounded, lanes 100, 200, -100, 0.
        in_valid = 1'b1;
        in_data  = {32'd0, 32'hFFFF_FF9C, 32'd200, 32'd100};
        step();
        in_valid = 1'b0;
        check("t1_busy", 32'(busy), 32'd1);
        cnt = 1;
        while (!out_valid && cnt < 20) begin
            step();
            cnt++;
        end
        check("t1_lat", 32'(cnt), 32'd5);
        check("t1_data", out_data, 32'h00CE_6432);
        step();
        check("t1_drained", 32'(busy), 32'd0);

        lane_cfg(2'd0, 32'h4000_0000, 6'h3F);
        lane_cfg(2'd1, 32'h8000_0000, 6'd0);
        lane_cfg(2'd2, 32'h4000_0000, 6'd2);
        lane_cfg(2'd3, 32'h2000_0000, 6'd0);
        // lane0 -3 -> -1, lane1 overflow -> 127, lane2 3<<2 -> 6, lane3 100*0.25 -> 25
        run_vec("t2_mix", {32'd100, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD}, 32'h1906_7FFF);
        glb_cfg(32'd10, 32'hFFFF_FF80, 32'd127);
        run_vec("t4_off", {32'd100, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD}, 32'h2310_8009);
        glb_cfg(32'd0, 32'd5, 32'hFFFF_FFFB);
        run_vec("t_inv_clamp", {32'd100, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD}, 32'hFBFB_FBFB);
        glb_cfg(32'd0, 32'hFFFF_FF80, 32'd127);
        run_vec("t_clamp_lo", {32'd0, 32'd0, 32'd0, 32'hFFFF_FC18}, 32'h0000_0080);

        // Lane3 mult rewritten on the accept cycle: this vector keeps the old 0.25.
        cfg_we = 1'b1; cfg_lane = 2'd3; cfg_mult = 32'h4000_0000; cfg_shift = 6'd0;
        run_vec("t_cfg_old", {32'd100, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD}, 32'h1906_7FFF);
        cfg_we = 1'b0;
        run_vec("t_cfg_new", {32'd100, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD}, 32'h3206_7FFF);

        // Backpressure stream of 8 vectors on default config.
        reset = 1'b1;
        step();
        reset = 1'b0;
        sent = 0; recv = 0; stalled_prev = 1'b0; held = '0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 6 && c < 9);
            in_valid  = (sent < 8);
            in_data   = bp_vec(sent);
            #1;
            if (stalled_prev) begin
                check("bp_hold_valid", 32'(out_valid), 32'd1);
                check("bp_hold_data", out_data, held);
            end
            if (out_valid && !out_ready) check("bp_in_ready", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (recv < 8) check("bp_data", out_data, bp_exp(recv));
                else          check("bp_extra", 32'(out_valid), 32'd0);
                recv++;
            end
            stalled_prev = out_valid && !out_ready;
            held = out_data;
            acc  = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_sent", 32'(sent), 32'd8);
        check("bp_recv", 32'(recv), 32'd8);

        // Reset with three vectors in flight and non-default config.
        lane_cfg(2'd0, 32'h2000_0000, 6'd0);
        glb_cfg(32'd5, 32'hFFFF_FF80, 32'd127);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = bp_vec(k + 1);
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rm_out_valid", 32'(out_valid), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_in_ready", 32'(in_ready), 32'd1);
        check("rm_out_data", out_data, 32'd0);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid) cnt++;
            step();
        end
        check("rm_no_out", 32'(cnt), 32'd0);
        run_vec("rm_defaults", {32'd0, 32'd0, 32'd0, 32'd100}, 32'h0000_0032);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
